// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: status codes, instruction codes and controller
// state encodings used by the hazard/stall controller and its bench.
package y86_pkg;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic load_use;
    logic ret_haz;
    logic mispredict;
  } hazard_t;

  // Instructions whose result arrives from memory late in the pipe.
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_control_if.sv
// Signal bundle between the Y86 pipeline datapath and its hazard controller.
// master = controller side, slave = datapath side.
interface pipe_control_if;
  import y86_pkg::*;

  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_of;
  logic [1:0]       m_stat;
  logic [1:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_cnd,
           alu_zf, alu_sf, alu_of, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           cc_zf, cc_sf, cc_of, state, halted, stall_cnt, bubble_cnt
  );

  modport slave (
    output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_cnd,
           alu_zf, alu_sf, alu_of, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           cc_zf, cc_sf, cc_of, state, halted, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/sat_counter16.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter16 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Y86 pipeline hazard controller: stall/bubble decode, condition-code register,
// RUN/DRAIN/HALT status machine and saturating stall/bubble counters.
module pipe_control
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  pipe_control_if.master    pif
);

  hazard_t          hz;
  ctrl_state_t      state_q;
  ctrl_state_t      state_nxt;
  logic [2:0]       cc_q;
  logic             m_bad;
  logic             w_bad;
  logic             f_stall;
  logic             d_stall;
  logic             d_bubble;
  logic             e_bubble;
  logic             m_bubble;
  logic             w_stall;
  logic             set_cc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  assign m_bad = (pif.m_stat != STAT_AOK);
  assign w_bad = (pif.W_stat != STAT_AOK);

  always_comb begin
    hz.load_use   = is_mem_load(pif.E_icode) && (pif.E_dstM != R_NONE) &&
                    ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    hz.ret_haz    = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) ||
                    (pif.M_icode == I_RET);
    hz.mispredict = (pif.E_icode == I_JXX) && !pif.e_cnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A load/use stall keeps the RET-bound instruction in decode, so it must not
  // also be bubbled there.
  always_comb begin
    state_nxt = state_q;
    f_stall   = hz.load_use | hz.ret_haz;
    d_stall   = hz.load_use;
    d_bubble  = hz.mispredict | (hz.ret_haz & ~hz.load_use);
    e_bubble  = hz.mispredict | hz.load_use;
    m_bubble  = 1'b0;
    w_stall   = w_bad;
    set_cc    = 1'b0;
    case (state_q)
      ST_RUN: begin
        m_bubble = m_bad | w_bad;
        set_cc   = (pif.E_icode == I_OPQ) && !m_bad && !w_bad;
        if (w_bad) begin
          state_nxt = ST_HALT;
        end else if (m_bad) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        m_bubble = 1'b1;
        if (w_bad) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        w_stall  = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Condition codes reset to "result was zero".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= 3'b100;
    end else if (set_cc) begin
      cc_q <= {pif.alu_zf, pif.alu_sf, pif.alu_of};
    end
  end

  sat_counter16 #(.DATA_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (f_stall),
    .count (stall_cnt)
  );

  sat_counter16 #(.DATA_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d_bubble | e_bubble),
    .count (bubble_cnt)
  );

  assign pif.F_stall    = f_stall;
  assign pif.D_stall    = d_stall;
  assign pif.D_bubble   = d_bubble;
  assign pif.E_bubble   = e_bubble;
  assign pif.M_bubble   = m_bubble;
  assign pif.W_stall    = w_stall;
  assign pif.set_cc     = set_cc;
  assign pif.cc_zf      = cc_q[2];
  assign pif.cc_sf      = cc_q[1];
  assign pif.cc_of      = cc_q[0];
  assign pif.state      = state_q;
  assign pif.halted     = (state_q == ST_HALT);
  assign pif.stall_cnt  = stall_cnt;
  assign pif.bubble_cnt = bubble_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Scenario bench for pipe_control: expected control vectors are queued when
// stimulus is applied and popped when the outputs are sampled at negedge.
module tb_pipe_control;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_control_if pif();

  pipe_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  int errors = 0;
  int checks = 0;

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  logic [6:0]  exp_q[$];
  logic [6:0]  ctrl;
  logic [6:0]  e;
  logic [15:0] exp_stall;
  logic [15:0] exp_bubble;

  assign ctrl = {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble,
                 pif.M_bubble, pif.W_stall, pif.set_cc};

  task automatic set_idle();
    pif.D_icode = 4'h1;
    pif.E_icode = 4'h1;
    pif.M_icode = 4'h1;
    pif.d_srcA  = R_NONE;
    pif.d_srcB  = R_NONE;
    pif.E_dstM  = R_NONE;
    pif.e_cnd   = 1'b1;
    pif.alu_zf  = 1'b0;
    pif.alu_sf  = 1'b0;
    pif.alu_of  = 1'b0;
    pif.m_stat  = STAT_AOK;
    pif.W_stat  = STAT_AOK;
  endtask

  // Word layout: D,E,M icode | srcA | srcB | E_dstM | e_cnd | expected ctrl
  task automatic drive_vec(input logic [31:0] w);
    pif.D_icode = w[31:28];
    pif.E_icode = w[27:24];
    pif.M_icode = w[23:20];
    pif.d_srcA  = w[19:16];
    pif.d_srcB  = w[15:12];
    pif.E_dstM  = w[11:8];
    pif.e_cnd   = w[7];
    exp_q.push_back(w[6:0]);
  endtask

  task automatic model_edge(input logic [6:0] v);
    if (v[6]) exp_stall++;
    if (v[4] | v[3]) exp_bubble++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stall  = '0;
    exp_bubble = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    exp_stall  = '0;
    exp_bubble = '0;
    @(posedge clk);
    #1;
    checks++;
    if (pif.state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", pif.state);
    end
    checks++;
    if ({pif.cc_zf, pif.cc_sf, pif.cc_of} !== 3'b100) begin
      errors++; $display("FAIL reset_cc: got %b want 100", {pif.cc_zf, pif.cc_sf, pif.cc_of});
    end
    checks++;
    if (pif.stall_cnt !== 16'd0 || pif.bubble_cnt !== 16'd0 || pif.halted !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: stall=%0d bubble=%0d halted=%b want 0 0 0",
                         pif.stall_cnt, pif.bubble_cnt, pif.halted);
    end
    rst_n = 1'b1;
    exp_q.push_back(7'b0000000);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++; $display("FAIL idle_ctrl: got %b want %b", ctrl, e);
    end
    model_edge(e);
    @(posedge clk);
    #1;
    checks++;
    if (pif.state !== 2'd0 || pif.stall_cnt !== exp_stall) begin
      errors++; $display("FAIL idle_after: state=%0d stall=%0d want 0 %0d",
                         pif.state, pif.stall_cnt, exp_stall);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] tbl [5];
    tbl[0] = {4'h1, I_MRMOVQ, 4'h1, 4'h3, R_NONE, 4'h3, 1'b1, 7'b1101000};
    tbl[1] = {4'h1, I_POPQ,   4'h1, 4'h2, 4'h4, 4'h4,   1'b1, 7'b1101000};
    tbl[2] = {4'h1, I_MRMOVQ, 4'h1, R_NONE, R_NONE, R_NONE, 1'b1, 7'b0000000};
    tbl[3] = {4'h1, I_MRMOVQ, 4'h1, 4'h2, 4'h5, 4'h3,   1'b1, 7'b0000000};
    tbl[4] = {4'h1, 4'h2,     4'h1, 4'h3, 4'h3, 4'h3,   1'b1, 7'b0000000};
    set_idle();
    for (int i = 0; i < 5; i++) begin
      drive_vec(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL load_use[%0d]: ctrl=%b want %b", i, ctrl, e);
      end
      model_edge(e);
      @(posedge clk);
      #1;
      checks++;
      if (pif.stall_cnt !== exp_stall || pif.bubble_cnt !== exp_bubble) begin
        errors++; $display("FAIL load_use_cnt[%0d]: stall=%0d bubble=%0d want %0d %0d",
                           i, pif.stall_cnt, pif.bubble_cnt, exp_stall, exp_bubble);
      end
    end
  endtask

  task automatic test_branch_ret();
    logic [31:0] tbl [7];
    tbl[0] = {I_RET, I_JXX,    4'h1,  R_NONE, R_NONE, R_NONE, 1'b0, 7'b1011000};
    tbl[1] = {4'h1,  I_JXX,    4'h1,  R_NONE, R_NONE, R_NONE, 1'b0, 7'b0011000};
    tbl[2] = {4'h1,  I_JXX,    4'h1,  R_NONE, R_NONE, R_NONE, 1'b1, 7'b0000000};
    tbl[3] = {4'h1,  4'h1,     I_RET, R_NONE, R_NONE, R_NONE, 1'b1, 7'b1010000};
    tbl[4] = {4'h1,  I_RET,    4'h1,  R_NONE, R_NONE, R_NONE, 1'b1, 7'b1010000};
    tbl[5] = {I_RET, I_MRMOVQ, 4'h1,  4'h3,   R_NONE, 4'h3,   1'b1, 7'b1101000};
    tbl[6] = {4'h1,  I_POPQ,   I_RET, R_NONE, 4'h6,   4'h6,   1'b1, 7'b1101000};
    set_idle();
    for (int i = 0; i < 7; i++) begin
      drive_vec(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL branch_ret[%0d]: ctrl=%b want %b", i, ctrl, e);
      end
      model_edge(e);
      @(posedge clk);
      #1;
    end
    checks++;
    if (pif.stall_cnt !== exp_stall || pif.bubble_cnt !== exp_bubble) begin
      errors++; $display("FAIL branch_ret_cnt: stall=%0d bubble=%0d want %0d %0d",
                         pif.stall_cnt, pif.bubble_cnt, exp_stall, exp_bubble);
    end
  endtask

  task automatic test_cc_drain();
    logic [31:0] tbl [4];
    logic [2:0]  cc_exp [4];
    logic [1:0]  st_exp [4];
    // {m_stat, W_stat, alu flags} packed into the srcA/srcB/dstM slots of this table
    tbl[0] = {4'h1, I_OPQ, 4'h1, 2'b00, STAT_AOK, 4'h0, 4'h3, 1'b1, 7'b0000001};
    tbl[1] = {4'h1, I_OPQ, 4'h1, 2'b00, STAT_AOK, 4'h2, 4'h4, 1'b1, 7'b0000100};
    tbl[2] = {4'h1, I_OPQ, 4'h1, 2'b00, STAT_AOK, 4'h0, 4'h7, 1'b1, 7'b0000100};
    tbl[3] = {4'h1, I_OPQ, 4'h1, 2'b00, STAT_ADR, 4'h0, 4'h7, 1'b1, 7'b0000110};
    cc_exp[0] = 3'b011; st_exp[0] = 2'd0;
    cc_exp[1] = 3'b011; st_exp[1] = 2'd1;
    cc_exp[2] = 3'b011; st_exp[2] = 2'd1;
    cc_exp[3] = 3'b011; st_exp[3] = 2'd2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pif.D_icode = tbl[i][31:28];
      pif.E_icode = tbl[i][27:24];
      pif.M_icode = tbl[i][23:20];
      pif.W_stat  = tbl[i][17:16];
      pif.m_stat  = tbl[i][13:12];
      pif.alu_zf  = tbl[i][10];
      pif.alu_sf  = tbl[i][9];
      pif.alu_of  = tbl[i][8];
      exp_q.push_back(tbl[i][6:0]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL cc_ctrl[%0d]: ctrl=%b want %b", i, ctrl, e);
      end
      model_edge(e);
      @(posedge clk);
      #1;
      checks++;
      if ({pif.cc_zf, pif.cc_sf, pif.cc_of} !== cc_exp[i] || pif.state !== st_exp[i]) begin
        errors++; $display("FAIL cc_state[%0d]: cc=%b state=%0d want %b %0d", i,
                           {pif.cc_zf, pif.cc_sf, pif.cc_of}, pif.state, cc_exp[i], st_exp[i]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    pif.E_icode = I_OPQ;
    pif.alu_of  = 1'b1;
    exp_q.push_back(7'b0000001);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++; $display("FAIL halt_pre_ctrl: ctrl=%b want %b", ctrl, e);
    end
    model_edge(e);
    @(posedge clk);
    #1;
    pif.W_stat = STAT_HLT;
    pif.alu_zf = 1'b1;
    exp_q.push_back(7'b0000110);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++; $display("FAIL halt_entry_ctrl: ctrl=%b want %b", ctrl, e);
    end
    model_edge(e);
    @(posedge clk);
    #1;
    checks++;
    if (pif.state !== 2'd2 || pif.halted !== 1'b1 ||
        {pif.cc_zf, pif.cc_sf, pif.cc_of} !== 3'b001) begin
      errors++; $display("FAIL halt_entry: state=%0d halted=%b cc=%b want 2 1 001",
                         pif.state, pif.halted, {pif.cc_zf, pif.cc_sf, pif.cc_of});
    end
    for (int i = 0; i < 10; i++) begin
      pif.D_icode = 4'($urandom_range(0, 15));
      pif.E_icode = (i % 2 == 0) ? I_OPQ : 4'($urandom_range(0, 15));
      pif.M_icode = 4'($urandom_range(0, 15));
      pif.d_srcA  = 4'($urandom_range(0, 15));
      pif.d_srcB  = 4'($urandom_range(0, 15));
      pif.E_dstM  = 4'($urandom_range(0, 15));
      pif.e_cnd   = 1'($urandom_range(0, 1));
      pif.m_stat  = (i < 5) ? STAT_AOK : STAT_INS;
      pif.W_stat  = (i < 5) ? STAT_AOK : 2'($urandom_range(0, 3));
      pif.alu_sf  = 1'b1;
      exp_q.push_back(7'b1100010);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e || pif.state !== 2'd2 || pif.halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold[%0d]: ctrl=%b state=%0d halted=%b want %b 2 1",
                           i, ctrl, pif.state, pif.halted, e);
      end
      model_edge(e);
      @(posedge clk);
      #1;
    end
    checks++;
    if (pif.stall_cnt !== exp_stall || pif.bubble_cnt !== exp_bubble ||
        {pif.cc_zf, pif.cc_sf, pif.cc_of} !== 3'b001) begin
      errors++; $display("FAIL halt_cnt: stall=%0d bubble=%0d cc=%b want %0d %0d 001",
                         pif.stall_cnt, pif.bubble_cnt, {pif.cc_zf, pif.cc_sf, pif.cc_of},
                         exp_stall, exp_bubble);
    end
  endtask

  task automatic test_reset_in_halt();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pif.state !== 2'd0 || pif.halted !== 1'b0 ||
        {pif.cc_zf, pif.cc_sf, pif.cc_of} !== 3'b100) begin
      errors++; $display("FAIL async_reset_state: state=%0d halted=%b cc=%b want 0 0 100",
                         pif.state, pif.halted, {pif.cc_zf, pif.cc_sf, pif.cc_of});
    end
    checks++;
    if (pif.stall_cnt !== 16'd0 || pif.bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset_cnt: stall=%0d bubble=%0d want 0 0",
                         pif.stall_cnt, pif.bubble_cnt);
    end
    do_reset();
    pif.m_stat = STAT_ADR;
    exp_q.push_back(7'b0000100);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++; $display("FAIL post_reset_ctrl: ctrl=%b want %b", ctrl, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pif.state !== 2'd1) begin
      errors++; $display("FAIL post_reset_state: state=%0d want 1", pif.state);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pif.E_icode = I_MRMOVQ;
    pif.E_dstM  = 4'h3;
    pif.d_srcA  = 4'h3;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (pif.stall_cnt !== 16'hFFFE || pif.bubble_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_near: stall=%h bubble=%h want fffe fffe",
                         pif.stall_cnt, pif.bubble_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (pif.stall_cnt !== 16'hFFFF || pif.bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: stall=%h bubble=%h want ffff ffff",
                         pif.stall_cnt, pif.bubble_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_ret();
    test_cc_drain();
    test_halt();
    test_reset_in_halt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
